ls_counter_gen: RTL



---
 rtl/ls_counter_gen_pkg.sv | 10 +
 rtl/ls_counter_gen_if.sv | 26 ++
 rtl/ls_counter_gen_next.sv | 30 +++
 rtl/ls_counter_gen.sv | 58 +++++
 4 files changed

// File: rtl/ls_counter_gen_pkg.sv
// Shared types for the ls_counter_gen counter family.
package ls_counter_gen_pkg;

  // Run/halt control state. RUN is the reset value, so it is encoded as 0.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/ls_counter_gen_if.sv
// Control/data bundle for ls_counter_gen: load, enables, mode and count outputs.
interface ls_counter_gen_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] D;
  logic             LOAD_n;
  logic             ENP;
  logic             ENT;
  logic             UP;
  logic             ONESHOT;
  logic [WIDTH-1:0] Q;
  logic             RCO;
  logic             DONE;

  // Driver side: supplies load/enable/mode, observes the count.
  modport master (
    output D, LOAD_n, ENP, ENT, UP, ONESHOT,
    input  Q, RCO, DONE
  );

  // Counter side.
  modport slave (
    input  D, LOAD_n, ENP, ENT, UP, ONESHOT,
    output Q, RCO, DONE
  );
endinterface

// File: rtl/ls_counter_gen_next.sv
// Combinational next-count logic: step, explicit wrap, terminal detect.
module ls_counter_next #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_up,
  input  logic             i_oneshot,
  output logic [WIDTH-1:0] o_next_q,
  output logic             o_at_term,
  output logic             o_halt
);
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] w_term;

  assign w_term    = i_up ? LP_MAX : '0;
  assign o_at_term = (i_q == w_term);
  assign o_halt    = o_at_term & i_oneshot;

  // Wrap is explicit so a non-power-of-two modulus never relies on rollover.
  always_comb begin
    o_next_q = i_q;
    if (o_at_term) begin
      if (!i_oneshot) o_next_q = i_up ? '0 : LP_MAX;
    end else begin
      o_next_q = i_up ? (i_q + WIDTH'(1)) : (i_q - WIDTH'(1));
    end
  end
endmodule

// File: rtl/ls_counter_gen.sv
// Modulo-N up/down counter with parallel load, ENP/ENT, RCO and one-shot halt.
module ls_counter_gen
  import ls_counter_gen_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic               CLK,
  input  logic               CLR,
  ls_counter_gen_if.slave    bus
);
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   LP_MOD = (WIDTH + 1)'(MODULUS);

  if (WIDTH < 1 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_params
    $error("ls_counter_gen: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  logic [WIDTH-1:0] r_q;
  state_t           r_state;
  logic [WIDTH-1:0] w_next_q;
  logic             w_at_term;
  logic             w_halt;
  logic             w_count;

  ls_counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .i_q       (r_q),
    .i_up      (bus.UP),
    .i_oneshot (bus.ONESHOT),
    .o_next_q  (w_next_q),
    .o_at_term (w_at_term),
    .o_halt    (w_halt)
  );

  assign w_count = bus.ENP & bus.ENT & (r_state == ST_RUN);

  // Priority: clear, load (saturating, ignores enables), count, else hold.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_q     <= '0;
      r_state <= ST_RUN;
    end else if (!bus.LOAD_n) begin
      r_q     <= ({1'b0, bus.D} < LP_MOD) ? bus.D : LP_MAX;
      r_state <= ST_RUN;
    end else if (w_count) begin
      r_q <= w_next_q;
      if (w_halt) r_state <= ST_HALT;
    end
  end

  assign bus.Q    = r_q;
  assign bus.DONE = (r_state == ST_HALT);
  // RCO ignores ENP so cascades behave like the TTL part; a halted stage never carries.
  assign bus.RCO  = bus.ENT & w_at_term & (r_state == ST_RUN);
endmodule
